// File: rtl/conv_window_feeder_if.sv
// Pixel-in / window-out bundle of the 3x3x3 window feeder.
// slave = feeder side, master = pixel source / window consumer side.
interface conv_window_feeder_if #(
    parameter int CW = 8
);
    logic              pix_valid_i;
    logic              pix_ready_o;
    logic [3*CW-1:0]   pix_data_i;
    logic              sof_i;
    logic              win_valid_o;
    logic [27*CW-1:0]  win_data_o;
    logic              win_last_o;
    logic              frame_done_o;

    modport slave (
        input  pix_valid_i, pix_data_i, sof_i,
        output pix_ready_o, win_valid_o, win_data_o, win_last_o, frame_done_o
    );

    modport master (
        output pix_valid_i, pix_data_i, sof_i,
        input  pix_ready_o, win_valid_o, win_data_o, win_last_o, frame_done_o
    );
endinterface

// File: rtl/conv_window_feeder.sv
// Streaming 3x3x3 window generator with two line buffers feeding the systolic array.
// Optional WIN_STRIDE2_EN: emit only windows whose bottom-right pixel sits at even row/col.
//
// state    | meaning
// S_IDLE   | ready, waiting for a pixel with sof_i (others are dropped)
// S_FILL   | rows 0..1 loading the line buffers, no windows
// S_STREAM | rows >= 2, windows emitted
// S_DONE   | one cycle after the last pixel, not ready, frame_done_o high
module conv_window_feeder #(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16,
    parameter int CW         = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    conv_window_feeder_if.slave   bus
);
    localparam int COLW = $clog2(IMG_WIDTH);
    localparam int ROWW = $clog2(IMG_HEIGHT);
    localparam int PW   = 3 * CW;
`ifdef WIN_STRIDE2_EN
    localparam int LAST_ROW = ((IMG_HEIGHT - 1) / 2) * 2;
    localparam int LAST_COL = ((IMG_WIDTH - 1) / 2) * 2;
`else
    localparam int LAST_ROW = IMG_HEIGHT - 1;
    localparam int LAST_COL = IMG_WIDTH - 1;
`endif

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [COLW-1:0]   r_col;
    logic [ROWW-1:0]   r_row;
    logic [PW-1:0]     r_lb0 [IMG_WIDTH];
    logic [PW-1:0]     r_lb1 [IMG_WIDTH];
    logic [PW-1:0]     r_win [3][3];
    logic              r_win_valid;
    logic              r_win_last;

    logic              w_ready;
    logic              w_xfer;
    logic              w_start;
    logic              w_accept;
    logic [COLW-1:0]   w_col_eff;
    logic [ROWW-1:0]   w_row_eff;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_frame_end;
    logic              w_emit;
    logic              w_win_last;
    logic [PW-1:0]     w_lb0_rd;
    logic [PW-1:0]     w_lb1_rd;
    logic [27*CW-1:0]  w_win_data;

    assign w_ready  = (r_state != S_DONE);
    assign w_xfer   = bus.pix_valid_i && w_ready;
    assign w_start  = w_xfer && bus.sof_i;
    assign w_accept = w_start || (w_xfer && (r_state == S_FILL || r_state == S_STREAM));

    // An sof pixel is always (0,0), whether it opens a frame or aborts one.
    assign w_col_eff   = w_start ? '0 : r_col;
    assign w_row_eff   = w_start ? '0 : r_row;
    assign w_col_last  = (w_col_eff == COLW'(IMG_WIDTH - 1));
    assign w_row_last  = (w_row_eff == ROWW'(IMG_HEIGHT - 1));
    assign w_frame_end = w_accept && w_col_last && w_row_last;

`ifdef WIN_STRIDE2_EN
    assign w_emit = w_accept && (w_row_eff >= ROWW'(2)) && (w_col_eff >= COLW'(2))
                    && !w_row_eff[0] && !w_col_eff[0];
`else
    assign w_emit = w_accept && (w_row_eff >= ROWW'(2)) && (w_col_eff >= COLW'(2));
`endif
    assign w_win_last = w_emit && (w_row_eff == ROWW'(LAST_ROW)) && (w_col_eff == COLW'(LAST_COL));

    assign w_lb0_rd = r_lb0[w_col_eff];
    assign w_lb1_rd = r_lb1[w_col_eff];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_state_nxt = S_FILL;
            S_FILL: begin
                if (w_start)
                    w_state_nxt = S_FILL;
                else if (w_xfer && r_row == ROWW'(1) && w_col_last)
                    w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (w_start)
                    w_state_nxt = S_FILL;
                else if (w_frame_end)
                    w_state_nxt = S_DONE;
            end
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_win_valid <= w_emit;
            r_win_last  <= w_win_last;
            if (w_accept) begin
                if (w_frame_end) begin
                    r_col <= '0;
                    r_row <= '0;
                end else if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_eff + ROWW'(1);
                end else begin
                    r_col <= w_col_eff + COLW'(1);
                    r_row <= w_row_eff;
                end
            end
        end
    end

    // Line buffers are never cleared; every entry is rewritten during FILL.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_lb0[w_col_eff] <= w_lb1_rd;
            r_lb1[w_col_eff] <= bus.pix_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    r_win[r][c] <= '0;
        end else if (w_accept) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= r_win[r][2];
            end
            r_win[0][2] <= w_lb0_rd;
            r_win[1][2] <= w_lb1_rd;
            r_win[2][2] <= bus.pix_data_i;
        end
    end

    // Shift register only moves on a transfer, so it holds steady during the valid cycle.
    always_comb begin
        w_win_data = '0;
        for (int ch = 0; ch < 3; ch++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    w_win_data[(9*ch + 3*r + c)*CW +: CW] = r_win[r][c][ch*CW +: CW];
    end

    assign bus.pix_ready_o  = w_ready;
    assign bus.win_valid_o  = r_win_valid;
    assign bus.win_last_o   = r_win_last;
    assign bus.win_data_o   = w_win_data;
    assign bus.frame_done_o = (r_state == S_DONE);
endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder: 5-wide frames, gaps, abort, async reset.
// Build with WIN_STRIDE2_EN defined for the stride-2 variant (5x5 frame).
module tb_conv_window_feeder;
    localparam int W = 5;
`ifdef WIN_STRIDE2_EN
    localparam int H      = 5;
    localparam int N_WIN  = 4;
    localparam int LAST_R = 4;
    localparam int LAST_C = 4;
`else
    localparam int H      = 4;
    localparam int N_WIN  = 6;
    localparam int LAST_R = 3;
    localparam int LAST_C = 4;
`endif

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk_i = ~clk_i;

    conv_window_feeder_if #(.CW(8)) bus ();

    conv_window_feeder #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CW(8)) dut (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int r, input int c, input int base);
        return {8'(base + r*16 + c + 2), 8'(base + r*16 + c + 1), 8'(base + r*16 + c)};
    endfunction

    function automatic logic [215:0] exp_win(input int r_bot, input int c_right, input int base);
        logic [215:0] v;
        v = '0;
        for (int ch = 0; ch < 3; ch++)
            for (int wr = 0; wr < 3; wr++)
                for (int wc = 0; wc < 3; wc++)
                    v[(9*ch + 3*wr + wc)*8 +: 8] = 8'(base + (r_bot-2+wr)*16 + (c_right-2+wc) + ch);
        return v;
    endfunction

    function automatic bit qualifies(input int r, input int c);
`ifdef WIN_STRIDE2_EN
        return (r >= 2) && (c >= 2) && (r % 2 == 0) && (c % 2 == 0);
`else
        return (r >= 2) && (c >= 2);
`endif
    endfunction

    // Entered and left at posedge+1; outputs checked one cycle after the offered pixel.
    task automatic step(input logic v, input logic sof, input logic [23:0] d,
                        input bit ew, input bit el, input bit ed,
                        input logic [215:0] edata, output bit got_win);
        bus.pix_valid_i = v;
        bus.sof_i       = sof;
        bus.pix_data_i  = d;
        @(negedge clk_i);
        if (v) chk("pix_ready", bus.pix_ready_o, 1'b1);
        @(posedge clk_i);
        #1;
        bus.pix_valid_i = 1'b0;
        bus.sof_i       = 1'b0;
        chk("win_valid", bus.win_valid_o, ew);
        chk("win_last", bus.win_last_o, el);
        chk("frame_done", bus.frame_done_o, ed);
        if (ew) chk("win_data", bus.win_data_o, edata);
        got_win = bus.win_valid_o;
    endtask

    task automatic send_frame(input int base, input bit gap, input int n_pix, input bit hand);
        int wins;
        int exp_wins;
        bit g;
        wins = 0;
        exp_wins = 0;
        for (int k = 0; k < n_pix; k++) begin
            int r;
            int c;
            bit q;
            bit l;
            bit dn;
            r  = k / W;
            c  = k % W;
            q  = qualifies(r, c);
            l  = (r == LAST_R) && (c == LAST_C);
            dn = (r == H-1) && (c == W-1);
            if (q) exp_wins++;
            step(1'b1, k == 0, pix(r, c, base), q, l, dn, exp_win(r, c, base), g);
            if (g) wins++;
            if (hand && r == 2 && c == 2) begin
                chk("byte0", bus.win_data_o[7:0], 8'h00);
                chk("byte8", bus.win_data_o[71:64], 8'h22);
                chk("byte9", bus.win_data_o[79:72], 8'h01);
            end
            if (gap) step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, g);
        end
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, g);
        chk("win_count", wins, exp_wins);
        if (n_pix == W*H) chk("win_total", wins, N_WIN);
    endtask

    initial begin
        bit g;
        bus.pix_valid_i = 1'b0;
        bus.sof_i       = 1'b0;
        bus.pix_data_i  = '0;
        #12;
        chk("rst_ready", bus.pix_ready_o, 1'b1);
        chk("rst_valid", bus.win_valid_o, 1'b0);
        chk("rst_data", bus.win_data_o, 216'd0);
        chk("rst_last", bus.win_last_o, 1'b0);
        chk("rst_done", bus.frame_done_o, 1'b0);
        @(posedge clk_i);
        #1;
        rst_n = 1'b1;

        // pixel without sof in IDLE is dropped
        step(1'b1, 1'b0, pix(3, 3, 0), 1'b0, 1'b0, 1'b0, '0, g);

        send_frame(0, 1'b0, W*H, 1'b1);
        send_frame(8'h20, 1'b1, W*H, 1'b0);

        // abort: new sof arrives where (2,3) of the old frame would be
        send_frame(8'h80, 1'b0, 2*W + 3, 1'b0);
        send_frame(0, 1'b0, W*H, 1'b1);

        // async reset while a window is on the outputs
        send_frame(8'h60, 1'b0, 2*W + 3, 1'b0);
        bus.pix_valid_i = 1'b1;
        bus.pix_data_i  = pix(2, 3, 8'h60);
        @(posedge clk_i);
        #1;
        bus.pix_valid_i = 1'b0;
        chk("pre_rst_valid", bus.win_valid_o, qualifies(2, 3));
        rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.win_valid_o, 1'b0);
        chk("arst_data", bus.win_data_o, 216'd0);
        chk("arst_ready", bus.pix_ready_o, 1'b1);
        @(posedge clk_i);
        #1;
        rst_n = 1'b1;
        send_frame(8'h40, 1'b0, W*H, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
